// File: rtl/bp_bimodal_btb.sv
// IF-stage branch predictor: bimodal saturating-counter table for B-type branches
// plus a direct-mapped BTB for JALR targets, trained from EX resolution.
module bp_bimodal_btb #(
  parameter int BHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int CNT_W     = 2,
  parameter int CNT_INIT  = 1,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       inst_addr_i,
  output logic              isbranch_o,
  output logic [31:0]       branch_addr_o,
  input  logic              upd_valid_i,
  input  logic [31:0]       upd_pc_i,
  input  logic              upd_is_cond_i,
  input  logic              upd_is_jalr_i,
  input  logic              upd_taken_i,
  input  logic [31:0]       upd_target_i,
  input  logic              upd_mispred_i,
  input  logic              perf_clr_i,
  output logic [PERF_W-1:0] perf_resolved_o,
  output logic [PERF_W-1:0] perf_mispred_o
);
  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 32 - BTB_IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  logic [CNT_W-1:0] r_cnt     [BHT_N];
  logic [BTB_N-1:0] r_btb_vld;
  logic [TAG_W-1:0] r_btb_tag [BTB_N];
  logic [31:0]      r_btb_tgt [BTB_N];
  logic [PERF_W-1:0] r_perf_res, r_perf_mis;

  logic [6:0]           w_opc;
  logic [2:0]           w_f3;
  logic [31:0]          w_b_imm, w_j_imm;
  logic [BHT_IDX_W-1:0] w_bht_idx, w_upd_bht_idx;
  logic [BTB_IDX_W-1:0] w_btb_idx, w_upd_btb_idx;
  logic [TAG_W-1:0]     w_tag, w_upd_tag;
  logic                 w_btb_wr;
  logic                 w_unused;

  assign w_opc   = inst_i[6:0];
  assign w_f3    = inst_i[14:12];
  assign w_b_imm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_j_imm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  assign w_bht_idx     = inst_addr_i[BHT_IDX_W+1:2];
  assign w_btb_idx     = inst_addr_i[BTB_IDX_W+1:2];
  assign w_tag         = inst_addr_i[31:BTB_IDX_W+2];
  assign w_upd_bht_idx = upd_pc_i[BHT_IDX_W+1:2];
  assign w_upd_btb_idx = upd_pc_i[BTB_IDX_W+1:2];
  assign w_upd_tag     = upd_pc_i[31:BTB_IDX_W+2];
  assign w_unused      = &{1'b0, inst_addr_i[1:0], upd_pc_i[1:0]};

  // Lookup reads table state directly: an update in the same cycle is not bypassed.
  always_comb begin
    isbranch_o    = 1'b0;
    branch_addr_o = '0;
    case (w_opc)
      OPC_BR:
        if (w_f3 != 3'b010 && w_f3 != 3'b011 && r_cnt[w_bht_idx][CNT_W-1]) begin
          isbranch_o    = 1'b1;
          branch_addr_o = inst_addr_i + w_b_imm;
        end
      OPC_JAL: begin
        isbranch_o    = 1'b1;
        branch_addr_o = inst_addr_i + w_j_imm;
      end
      OPC_JALR:
        if (w_f3 == 3'b000 && r_btb_vld[w_btb_idx] && r_btb_tag[w_btb_idx] == w_tag) begin
          isbranch_o    = 1'b1;
          branch_addr_o = r_btb_tgt[w_btb_idx];
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) r_cnt[i] <= CNT_RST;
    end else if (upd_valid_i && upd_is_cond_i) begin
      if (upd_taken_i && r_cnt[w_upd_bht_idx] != CNT_MAX)
        r_cnt[w_upd_bht_idx] <= r_cnt[w_upd_bht_idx] + 1'b1;
      else if (!upd_taken_i && r_cnt[w_upd_bht_idx] != '0)
        r_cnt[w_upd_bht_idx] <= r_cnt[w_upd_bht_idx] - 1'b1;
    end
  end

  // A cond+jalr update is malformed; it trains the counter only.
  assign w_btb_wr = upd_valid_i && upd_is_jalr_i && upd_taken_i && !upd_is_cond_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_btb_vld <= '0;
    else if (w_btb_wr) r_btb_vld[w_upd_btb_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_upd_btb_idx] <= w_upd_tag;
      r_btb_tgt[w_upd_btb_idx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_res <= '0;
      r_perf_mis <= '0;
    end else if (perf_clr_i) begin
      r_perf_res <= '0;
      r_perf_mis <= '0;
    end else if (upd_valid_i) begin
      r_perf_res <= r_perf_res + 1'b1;
      if (upd_mispred_i) r_perf_mis <= r_perf_mis + 1'b1;
    end
  end

  assign perf_resolved_o = r_perf_res;
  assign perf_mispred_o  = r_perf_mis;
endmodule

// File: tb/tb_bp_bimodal_btb.sv
// Directed + randomized bench for bp_bimodal_btb against a PC-arithmetic reference model.
module tb_bp_bimodal_btb;
  localparam int BHT_IDX_W = 6;
  localparam int BTB_IDX_W = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_INIT  = 1;
  localparam int PERF_W    = 32;
  localparam int BHT_N     = 1 << BHT_IDX_W;
  localparam int BTB_N     = 1 << BTB_IDX_W;
  localparam int CNT_TOP   = (1 << CNT_W) - 1;
  localparam int CNT_HALF  = 1 << (CNT_W - 1);

  logic clk, rst;
  logic [31:0] inst_i, inst_addr_i, branch_addr_o;
  logic isbranch_o;
  logic upd_valid_i, upd_is_cond_i, upd_is_jalr_i, upd_taken_i, upd_mispred_i, perf_clr_i;
  logic [31:0] upd_pc_i, upd_target_i;
  logic [PERF_W-1:0] perf_resolved_o, perf_mispred_o;

  int tests = 0;
  int fails = 0;

  int unsigned  m_cnt [BHT_N];
  bit           m_bv  [BTB_N];
  int unsigned  m_btag[BTB_N];
  logic [31:0]  m_btgt[BTB_N];
  int unsigned  m_res, m_mis;

  bp_bimodal_btb #(.BHT_IDX_W(BHT_IDX_W), .BTB_IDX_W(BTB_IDX_W), .CNT_W(CNT_W),
                   .CNT_INIT(CNT_INIT), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .isbranch_o(isbranch_o), .branch_addr_o(branch_addr_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_is_cond_i(upd_is_cond_i),
    .upd_is_jalr_i(upd_is_jalr_i), .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_mispred_i(upd_mispred_i), .perf_clr_i(perf_clr_i),
    .perf_resolved_o(perf_resolved_o), .perf_mispred_o(perf_mispred_o));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd2, f3, 5'd1, opc};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_N; i++) m_cnt[i] = CNT_INIT;
    for (int i = 0; i < BTB_N; i++) m_bv[i] = 1'b0;
    m_res = 0;
    m_mis = 0;
  endtask

  // Expected prediction from instruction semantics and model tables.
  task automatic model_pred(output logic exp_isb, output logic [31:0] exp_addr);
    int          bidx, tidx;
    logic [12:0] bimm;
    logic [20:0] jimm;
    bidx = int'((inst_addr_i >> 2) % BHT_N);
    tidx = int'((inst_addr_i >> 2) % BTB_N);
    bimm = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    jimm = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    exp_isb  = 1'b0;
    exp_addr = 32'd0;
    if (inst_i[6:0] == 7'h63 && inst_i[14:12] != 3'd2 && inst_i[14:12] != 3'd3) begin
      if (m_cnt[bidx] >= CNT_HALF) begin
        exp_isb  = 1'b1;
        exp_addr = inst_addr_i + 32'($signed(bimm));
      end
    end else if (inst_i[6:0] == 7'h6f) begin
      exp_isb  = 1'b1;
      exp_addr = inst_addr_i + 32'($signed(jimm));
    end else if (inst_i[6:0] == 7'h67 && inst_i[14:12] == 3'd0) begin
      if (m_bv[tidx] && m_btag[tidx] == (inst_addr_i >> (BTB_IDX_W + 2))) begin
        exp_isb  = 1'b1;
        exp_addr = m_btgt[tidx];
      end
    end
  endtask

  task automatic model_update();
    int bidx, tidx;
    bidx = int'((upd_pc_i >> 2) % BHT_N);
    tidx = int'((upd_pc_i >> 2) % BTB_N);
    if (upd_valid_i) begin
      if (upd_is_cond_i) begin
        if (upd_taken_i && m_cnt[bidx] < CNT_TOP) m_cnt[bidx]++;
        else if (!upd_taken_i && m_cnt[bidx] > 0) m_cnt[bidx]--;
      end else if (upd_is_jalr_i && upd_taken_i) begin
        m_bv[tidx]   = 1'b1;
        m_btag[tidx] = upd_pc_i >> (BTB_IDX_W + 2);
        m_btgt[tidx] = upd_target_i;
      end
    end
    if (perf_clr_i) begin
      m_res = 0;
      m_mis = 0;
    end else if (upd_valid_i) begin
      m_res++;
      if (upd_mispred_i) m_mis++;
    end
  endtask

  task automatic check_all(input string tag);
    logic        ei;
    logic [31:0] ea;
    model_pred(ei, ea);
    chk({tag, "_isb"}, {31'd0, isbranch_o}, {31'd0, ei});
    chk({tag, "_addr"}, branch_addr_o, ea);
    chk({tag, "_res"}, perf_resolved_o, m_res);
    chk({tag, "_mis"}, perf_mispred_o, m_mis);
  endtask

  task automatic idle_upd();
    upd_valid_i = 0; upd_pc_i = 0; upd_is_cond_i = 0; upd_is_jalr_i = 0;
    upd_taken_i = 0; upd_target_i = 0; upd_mispred_i = 0; perf_clr_i = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit cond, input bit jalr, input bit tk,
                     input logic [31:0] tgt, input bit mp);
    upd_valid_i = 1; upd_pc_i = pc; upd_is_cond_i = cond; upd_is_jalr_i = jalr;
    upd_taken_i = tk; upd_target_i = tgt; upd_mispred_i = mp;
  endtask

  // Called just after a falling edge: check, take the rising edge, drop update inputs.
  task automatic tick(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    if (rst) model_update();
    @(negedge clk);
    idle_upd();
  endtask

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 255)) << 2);
  endfunction

  logic [31:0] beq100, jalr0;

  initial begin
    rst = 0;
    idle_upd();
    model_reset();
    beq100 = enc_b(13'd16, 3'b000);
    jalr0  = enc_i(7'h67, 3'b000, 12'd0);
    inst_i = beq100; inst_addr_i = 32'h100;
    // 1: outputs during and after reset
    #2 check_all("t1_in_reset");
    chk("t1_isb_const", {31'd0, isbranch_o}, 32'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    tick("t1_beq");
    // 2: two taken updates saturate toward 3
    upd(32'h100, 1, 0, 1, 0, 0); tick("t2_u1");
    upd(32'h100, 1, 0, 1, 0, 0); tick("t2_u2");
    #1 chk("t2_taken", {31'd0, isbranch_o}, 32'd1);
    chk("t2_target", branch_addr_o, 32'h110);
    upd(32'h100, 1, 0, 1, 0, 0); tick("t2_u3");
    chk("t2_sat", m_cnt[(32'h100 >> 2) % BHT_N], 3);
    // 3: hysteresis
    upd(32'h100, 1, 0, 0, 0, 1); tick("t3_nt1");
    #1 chk("t3_still_taken", {31'd0, isbranch_o}, 32'd1);
    upd(32'h100, 1, 0, 0, 0, 1); tick("t3_nt2");
    #1 chk("t3_not_taken", {31'd0, isbranch_o}, 32'd0);
    // 4: JALR BTB miss, fill, tag mismatch at aliasing PC
    inst_i = jalr0; inst_addr_i = 32'h200;
    #1 chk("t4_miss", {31'd0, isbranch_o}, 32'd0);
    upd(32'h200, 0, 1, 1, 32'h400, 0); tick("t4_fill");
    #1 chk("t4_hit", branch_addr_o, 32'h400);
    inst_addr_i = 32'h200 + (32'd1 << (BTB_IDX_W + 2));
    tick("t4_alias");
    chk("t4_alias_const", {31'd0, isbranch_o}, 32'd0);
    // 5: same-cycle lookup/update at one index sees old counter
    inst_i = enc_b(13'h1ff8, 3'b001); inst_addr_i = 32'h304;
    upd(32'h304, 1, 0, 1, 0, 0);
    #1 chk("t5_same", {31'd0, isbranch_o}, 32'd0);
    tick("t5_same_m");
    #1 chk("t5_next", {31'd0, isbranch_o}, 32'd1);
    chk("t5_next_addr", branch_addr_o, 32'h2fc);
    // JAL and illegal funct3
    inst_i = enc_j(21'h1ffff0); inst_addr_i = 32'h1000; tick("t5_jal");
    inst_i = enc_b(13'd16, 3'b010); inst_addr_i = 32'h100; tick("t5_ill");
    // 6: perf counters and clear priority
    perf_clr_i = 1; tick("t6_clr0");
    for (int i = 0; i < 5; i++) begin
      upd(32'h40 + 32'(i * 4), 0, 0, 1, 0, i < 2);
      tick("t6_upd");
    end
    #1 chk("t6_res5", perf_resolved_o, 32'd5);
    chk("t6_mis2", perf_mispred_o, 32'd2);
    upd(32'h60, 1, 0, 1, 0, 1); perf_clr_i = 1; tick("t6_clr");
    #1 chk("t6_res0", perf_resolved_o, 32'd0);
    chk("t6_mis0", perf_mispred_o, 32'd0);
    // cond+jalr both set: counter only, no BTB entry
    inst_i = jalr0; inst_addr_i = 32'h500;
    upd(32'h500, 1, 1, 1, 32'h800, 0); tick("t6_both");
    tick("t6_both_after");
    chk("t6_both_const", {31'd0, isbranch_o}, 32'd0);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0, 1: inst_i = enc_b(13'($urandom) & 13'h1ffe, 3'($urandom));
        2:    inst_i = enc_j(21'($urandom) & 21'h1ffffe);
        3:    inst_i = enc_i(7'h67, ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0, 12'($urandom));
        default: inst_i = enc_i(7'($urandom), 3'($urandom), 12'($urandom));
      endcase
      inst_addr_i = rnd_pc();
      if ($urandom_range(0, 1) == 1)
        upd(rnd_pc(), $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            32'($urandom) & 32'hfffffffc, $urandom_range(0, 3) == 0);
      perf_clr_i = ($urandom_range(0, 39) == 0);
      tick("rnd");
    end
    // asynchronous reset mid-cycle
    inst_i = beq100; inst_addr_i = 32'h100;
    upd(32'h100, 1, 0, 1, 0, 0); tick("t6_pre1");
    upd(32'h100, 1, 0, 1, 0, 1); tick("t6_pre2");
    #2 rst = 0;
    model_reset();
    #1 check_all("t6_async_rst");
    chk("t6_rst_isb", {31'd0, isbranch_o}, 32'd0);
    chk("t6_rst_res", perf_resolved_o, 32'd0);
    @(negedge clk);
    rst = 1;
    inst_i = jalr0; inst_addr_i = 32'h200;
    tick("t6_post_rst_jalr");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
